systolic_engine_rc: RTL

//  Parametrised weight-stationary systolic engine with a ROWS x COLS array of signed MAC cells.

---
 rtl/systolic_engine_rc.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_engine_rc.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_engine_rc
//  Description : Weight-stationary ROWS x COLS systolic MAC array with weight
//                load sequencing, activation skew, output de-skew, valid
//                tracking, result hold and per-column repair masking.
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_engine_rc #(
    parameter int ROWS              = 8,
    parameter int COLS              = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(ROWS) + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                w_valid,
    output logic                                w_ready,
    input  logic [COLS*WEIGHT_WIDTH-1:0]        w_row,
    input  logic                                a_valid,
    input  logic                                a_last,
    output logic                                a_ready,
    input  logic [ROWS*ACTIVATION_WIDTH-1:0]    a_vec,
    input  logic [COLS-1:0]                     col_disable,
    output logic                                ps_valid,
    output logic [COLS*PARTIAL_SUM_WIDTH-1:0]   ps_vec,
    output logic                                busy
);

    localparam int c_WW    = WEIGHT_WIDTH;
    localparam int c_AW    = ACTIVATION_WIDTH;
    localparam int c_PSW   = PARTIAL_SUM_WIDTH;
    // End-to-end latency from acceptance to aligned result
    localparam int c_L     = ROWS + COLS - 1;
    localparam int c_CNT_W = $clog2(c_L + 1);
    localparam int c_PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [c_PTR_W-1:0] c_LAST_ROW = c_PTR_W'(ROWS - 1);
    localparam logic [c_CNT_W-1:0] c_L_CNT    = c_CNT_W'(c_L);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   w_ptr_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_w_ready;
    logic                 r_a_ready;

    logic                 w_w_accept;
    logic                 w_a_accept;
    logic [c_PTR_W-1:0]   w_wr_row;
    logic [ROWS-1:0]      w_row_we;
    logic                 w_out_valid;

    // Activation entering each row's skew line, activation seen by each cell,
    // partial sum leaving each cell, and each column after de-skew
    logic signed [c_AW-1:0]  w_act_in   [ROWS];
    logic signed [c_AW-1:0]  w_cell_act [ROWS][COLS];
    logic signed [c_PSW-1:0] w_cell_psum[ROWS][COLS];
    logic signed [c_PSW-1:0] w_col_out  [COLS];

    logic [COLS*c_PSW-1:0]   r_hold;

    assign w_w_accept = w_valid & r_w_ready;
    assign w_a_accept = a_valid & r_a_ready;
    // First beat of a load always targets row 0; the pointer is only meaningful in LOAD
    assign w_wr_row   = (r_state == S_IDLE) ? '0 : r_ptr;

    assign w_ready    = r_w_ready;
    assign a_ready    = r_a_ready;
    assign busy       = (r_state != S_IDLE);
    assign ps_valid   = w_out_valid;

    // State, load pointer, drain counter and registered ready flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_w_ready <= 1'b0;
            r_a_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            // Readies follow the state being entered so they stay low during reset
            r_w_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            r_a_ready <= (w_state_nxt == S_STREAM);
        end
    end

    // Next-state sequencing: load ROWS weight beats, stream, then drain the pipe
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_w_accept) begin
                    if (ROWS == 1) begin
                        w_state_nxt = S_STREAM;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_ptr_nxt   = c_PTR_W'(1);
                    end
                end
            end
            S_LOAD: begin
                if (w_w_accept) begin
                    if (r_ptr == c_LAST_ROW) begin
                        w_state_nxt = S_STREAM;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_ptr_nxt   = r_ptr + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (w_a_accept && a_last) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = c_L_CNT;
                end
            end
            S_DRAIN: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        // Unaccepted cycles inject a zero bubble into the array
        assign w_act_in[gr] = w_a_accept ? $signed(a_vec[gr*c_AW +: c_AW]) : '0;
        assign w_row_we[gr] = w_w_accept && (w_wr_row == c_PTR_W'(gr));

        if (gr == 0) begin : g_skew_none
            assign w_cell_act[gr][0] = w_act_in[gr];
        end else begin : g_skew
            logic signed [c_AW-1:0] r_skew [gr];

            // Delay row gr activation by gr cycles so it meets the psum wavefront
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < gr; i++) r_skew[i] <= '0;
                end else begin
                    r_skew[0] <= w_act_in[gr];
                    for (int i = 1; i < gr; i++) r_skew[i] <= r_skew[i-1];
                end
            end

            assign w_cell_act[gr][0] = r_skew[gr-1];
        end

        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            logic signed [c_WW-1:0]  r_weight;
            logic signed [c_PSW-1:0] r_psum;
            logic signed [c_PSW-1:0] w_psum_in;
            logic signed [c_PSW-1:0] w_prod;

            if (gr == 0) begin : g_top
                assign w_psum_in = '0;
            end else begin : g_below
                assign w_psum_in = w_cell_psum[gr-1][gc];
            end

            // Operands are sign-extended to the full sum width before multiplying
            assign w_prod = c_PSW'(w_cell_act[gr][gc]) * c_PSW'(r_weight);

            // Stationary weight capture and multiply-accumulate
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_weight <= '0;
                    r_psum   <= '0;
                end else begin
                    if (w_row_we[gr]) r_weight <= w_row[gc*c_WW +: c_WW];
                    r_psum <= w_psum_in + w_prod;
                end
            end

            assign w_cell_psum[gr][gc] = r_psum;

            if (gc < COLS - 1) begin : g_pass
                logic signed [c_AW-1:0] r_act;

                // Forward the activation to the right-hand neighbour
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) r_act <= '0;
                    else        r_act <= w_cell_act[gr][gc];
                end

                assign w_cell_act[gr][gc+1] = r_act;
            end
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_deskew
        localparam int c_DLY = COLS - 1 - gc;

        if (c_DLY == 0) begin : g_direct
            assign w_col_out[gc] = w_cell_psum[ROWS-1][gc];
        end else begin : g_delay
            logic signed [c_PSW-1:0] r_dly [c_DLY];

            // Hold earlier columns back so all columns of a vector emerge together
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c_DLY; i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= w_cell_psum[ROWS-1][gc];
                    for (int i = 1; i < c_DLY; i++) r_dly[i] <= r_dly[i-1];
                end
            end

            assign w_col_out[gc] = r_dly[c_DLY-1];
        end
    end

    if (c_L == 1) begin : g_vsr_one
        logic r_vsr;

        // Single-stage valid tracking for the degenerate 1x1 array
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_vsr <= 1'b0;
            else        r_vsr <= w_a_accept;
        end

        assign w_out_valid = r_vsr;
    end else begin : g_vsr
        logic [c_L-1:0] r_vsr;

        // Valid bit travels alongside the data wavefront for c_L cycles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_vsr <= '0;
            else        r_vsr <= {r_vsr[c_L-2:0], w_a_accept};
        end

        assign w_out_valid = r_vsr[c_L-1];
    end

    // Remember the last valid result so the output holds between results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_out_valid) begin
            for (int c = 0; c < COLS; c++) r_hold[c*c_PSW +: c_PSW] <= w_col_out[c];
        end
    end

    // Output mux: live result when valid, held result otherwise, repaired columns forced to 0
    always_comb begin
        ps_vec = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_disable[c]) begin
                ps_vec[c*c_PSW +: c_PSW] = w_out_valid ? w_col_out[c] : r_hold[c*c_PSW +: c_PSW];
            end
        end
    end

endmodule
`default_nettype wire
